// File: rtl/fmeter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fmeter_pkg
// Description : Shared constants and types for the frequency meter display
//               path: active-high 7-segment glyphs (bit 0 = segment a),
//               digit slot indices and the slot state enumeration.
// Revision    : 1.0 - initial release
// ============================================================================
package fmeter_pkg;

    // Glyphs, active-high, {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    // Digit slot order within a frame: units first, thousands last
    localparam logic [1:0] DIG_U = 2'd0;
    localparam logic [1:0] DIG_D = 2'd1;
    localparam logic [1:0] DIG_H = 2'd2;
    localparam logic [1:0] DIG_T = 2'd3;

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } slot_state_t;

endpackage
`default_nettype wire

// File: rtl/bcd_to_seg7.sv
`default_nettype none
// ============================================================================
// Module      : bcd_to_seg7
// Description : Combinational 4-bit to 7-segment decoder, active-high output.
//               Codes 10-15 render a dash (segment g only) as an error mark.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_seg7
    import fmeter_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    // Glyph lookup
    always_comb begin
        o_seg = SEG_DASH;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_driver
// Description : 4-digit common-anode multiplexed 7-segment driver. Captures
//               BCD results into a shadow register on LOAD and transfers them
//               to the display register only at frame boundaries. Each digit
//               slot lasts REFRESH_DIV cycles, the first BLANK_CYC of which
//               keep all anodes off. SEG/AN/DP are registered.
//               Optional macro FMETER_LZB_EN enables leading-zero blanking.
//               Constraints: REFRESH_DIV >= 4, 1 <= BLANK_CYC < REFRESH_DIV.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_driver
    import fmeter_pkg::*;
#(
    parameter int REFRESH_DIV    = 1000,
    parameter int BLANK_CYC      = 2,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       LOAD,
    input  logic [3:0] BCD_T,
    input  logic [3:0] BCD_H,
    input  logic [3:0] BCD_D,
    input  logic [3:0] BCD_U,
    output logic [6:0] SEG,
    output logic       DP,
    output logic [3:0] AN,
    output logic       FRAME
);

    localparam int              c_PW         = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [c_PW-1:0] c_PRESC_LAST = c_PW'(REFRESH_DIV - 1);
    localparam logic [c_PW-1:0] c_BLANK_LAST = c_PW'(BLANK_CYC - 1);
    localparam logic [6:0]      c_SEG_IDLE   = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [3:0]      c_AN_IDLE    = (AN_ACTIVE_LOW != 0) ? 4'hF : 4'h0;
    localparam logic            c_DP_IDLE    = (SEG_ACTIVE_LOW != 0);

    logic [c_PW-1:0] r_presc;
    logic [1:0]      r_idx;
    slot_state_t     r_state;
    slot_state_t     w_state_next;
    logic            r_first;
    logic [15:0]     r_shadow;      // {T,H,D,U}
    logic [15:0]     r_disp;        // {T,H,D,U}
    logic [6:0]      r_seg;
    logic [3:0]      r_an;
    logic            r_dp;
    logic            r_frame;

    logic            w_wrap;
    logic            w_boundary;
    logic [15:0]     w_in;
    logic [3:0]      w_digit;
    logic [6:0]      w_glyph;
    logic            w_lit;
    logic            w_show;
    logic [3:0]      w_an_hi;
    logic [6:0]      w_seg_hi;

    assign w_wrap     = (r_presc == c_PRESC_LAST);
    // First cycle out of reset counts as a boundary so a fresh frame starts at once
    assign w_boundary = r_first | (w_wrap & (r_idx == DIG_T));
    assign w_in       = {BCD_T, BCD_H, BCD_D, BCD_U};
    assign w_digit    = r_disp[{r_idx, 2'b00} +: 4];

    bcd_to_seg7 u_dec (
        .i_bcd (w_digit),
        .o_seg (w_glyph)
    );

`ifdef FMETER_LZB_EN
    logic w_t_nz;
    logic w_h_nz;
    logic w_d_nz;

    assign w_t_nz = (r_disp[15:12] != 4'd0);
    assign w_h_nz = (r_disp[11:8]  != 4'd0);
    assign w_d_nz = (r_disp[7:4]   != 4'd0);

    // A digit is suppressed only while every more-significant digit is zero
    always_comb begin
        w_lit = 1'b1;
        case (r_idx)
            DIG_T:   w_lit = w_t_nz;
            DIG_H:   w_lit = w_t_nz | w_h_nz;
            DIG_D:   w_lit = w_t_nz | w_h_nz | w_d_nz;
            default: w_lit = 1'b1;
        endcase
    end
`else
    assign w_lit = 1'b1;
`endif

    assign w_show   = (r_state == SHOW) && w_lit;
    assign w_an_hi  = w_show ? (4'b0001 << r_idx) : 4'b0000;
    assign w_seg_hi = w_show ? w_glyph : SEG_OFF;

    // Slot state register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= BLANK;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next slot state, tracking the value the prescaler takes on this edge
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            BLANK:   if (r_presc == c_BLANK_LAST) w_state_next = SHOW;
            SHOW:    if (w_wrap)                  w_state_next = BLANK;
            default: w_state_next = BLANK;
        endcase
    end

    // Prescaler, digit index, shadow/display capture and registered outputs
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_presc  <= '0;
            r_idx    <= DIG_U;
            r_first  <= 1'b1;
            r_shadow <= '0;
            r_disp   <= '0;
            r_seg    <= c_SEG_IDLE;
            r_an     <= c_AN_IDLE;
            r_dp     <= c_DP_IDLE;
            r_frame  <= 1'b0;
        end else begin
            r_first <= 1'b0;
            if (w_wrap) begin
                r_presc <= '0;
                r_idx   <= r_idx + 2'd1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
            if (LOAD) begin
                r_shadow <= w_in;
            end
            // A LOAD on the boundary cycle goes straight to the new frame
            if (w_boundary) begin
                r_disp <= LOAD ? w_in : r_shadow;
            end
            r_frame <= w_boundary;
            r_seg   <= (SEG_ACTIVE_LOW != 0) ? ~w_seg_hi : w_seg_hi;
            r_an    <= (AN_ACTIVE_LOW != 0) ? ~w_an_hi : w_an_hi;
            r_dp    <= c_DP_IDLE;
        end
    end

    assign SEG   = r_seg;
    assign DP    = r_dp;
    assign AN    = r_an;
    assign FRAME = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_driver
// Description : Self-checking bench for seg7_scan_driver (REFRESH_DIV=8,
//               BLANK_CYC=2, active-low). Expected frame contents are queued
//               by the stimulus; a monitor pops one per FRAME pulse and checks
//               every output cycle of that frame. Honours FMETER_LZB_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       LOAD;
    logic [3:0] BCD_T;
    logic [3:0] BCD_H;
    logic [3:0] BCD_D;
    logic [3:0] BCD_U;
    logic [6:0] SEG;
    logic       DP;
    logic [3:0] AN;
    logic       FRAME;

    always #5 CLK = ~CLK;

    seg7_scan_driver #(
        .REFRESH_DIV    (8),
        .BLANK_CYC      (2),
        .SEG_ACTIVE_LOW (1),
        .AN_ACTIVE_LOW  (1)
    ) u_dut (
        .CLK   (CLK),
        .RESET (RESET),
        .LOAD  (LOAD),
        .BCD_T (BCD_T),
        .BCD_H (BCD_H),
        .BCD_D (BCD_D),
        .BCD_U (BCD_U),
        .SEG   (SEG),
        .DP    (DP),
        .AN    (AN),
        .FRAME (FRAME)
    );

    typedef struct {
        logic [15:0] dig;   // {T,H,D,U}
        logic [3:0]  lit;   // slot s lit when lit[s]
        int          ncyc;  // output cycles to check after FRAME (31 = whole frame)
    } exp_frame_t;

    exp_frame_t q[$];
    int         n_cmp = 0;
    int         n_fail = 0;
    bit         mon_skip = 1'b0;
    bit         mon_active = 1'b0;
    int         mon_j = 0;
    exp_frame_t mon_cur;

    // Active-high reference glyphs, bit 0 = segment a
    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'd0:    return 7'b0111111;
            4'd1:    return 7'b0000110;
            4'd2:    return 7'b1011011;
            4'd3:    return 7'b1001111;
            4'd4:    return 7'b1100110;
            4'd5:    return 7'b1101101;
            4'd6:    return 7'b1111101;
            4'd7:    return 7'b0000111;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1101111;
            default: return 7'b1000000;
        endcase
    endfunction

    task automatic push_exp(input logic [3:0] t, input logic [3:0] h,
                            input logic [3:0] d, input logic [3:0] u, input int ncyc);
        exp_frame_t e;
        e.dig  = {t, h, d, u};
        e.ncyc = ncyc;
`ifdef FMETER_LZB_EN
        e.lit[3] = (t != 4'd0);
        e.lit[2] = (t != 4'd0) || (h != 4'd0);
        e.lit[1] = (t != 4'd0) || (h != 4'd0) || (d != 4'd0);
        e.lit[0] = 1'b1;
`else
        e.lit = 4'hF;
`endif
        q.push_back(e);
    endtask

    task automatic check_cycle(input exp_frame_t e, input int j);
        int         s;
        int         k;
        logic [3:0] ean;
        logic [6:0] eseg;
        bit         chk_seg;
        s = (j - 1) / 8;
        k = (j - 1) % 8;
        if (k < 2) begin
            ean = 4'hF; eseg = 7'h7F; chk_seg = 1'b1;
        end else if (e.lit[s]) begin
            ean = ~(4'b0001 << s); eseg = ~glyph(e.dig[s*4 +: 4]); chk_seg = 1'b1;
        end else begin
            ean = 4'hF; eseg = 7'h7F; chk_seg = 1'b0;
        end
        n_cmp++;
        if (AN !== ean || (chk_seg && SEG !== eseg) || DP !== 1'b1 || FRAME !== 1'b0) begin
            n_fail++;
            $display("FAIL slot%0d_cyc%0d: AN=%b SEG=%b DP=%b FRAME=%b, required AN=%b SEG=%b(chk=%0d) DP=1 FRAME=0",
                     s, k, AN, SEG, DP, FRAME, ean, eseg, chk_seg);
        end
    endtask

    task automatic check_direct(input string tag, input logic [3:0] ean,
                                input logic [6:0] eseg, input logic efr);
        n_cmp++;
        if (AN !== ean || SEG !== eseg || DP !== 1'b1 || FRAME !== efr) begin
            n_fail++;
            $display("FAIL %s: AN=%b SEG=%b DP=%b FRAME=%b, required AN=%b SEG=%b DP=1 FRAME=%b",
                     tag, AN, SEG, DP, FRAME, ean, eseg, efr);
        end
    endtask

    task automatic do_load(input logic [3:0] t, input logic [3:0] h,
                           input logic [3:0] d, input logic [3:0] u);
        LOAD = 1'b1; BCD_T = t; BCD_H = h; BCD_D = d; BCD_U = u;
        @(posedge CLK); #1;
        LOAD = 1'b0;
    endtask

    task automatic wait_frame(input string tag);
        int t;
        t = 0;
        do begin
            @(posedge CLK); #1;
            t++;
        end while (FRAME !== 1'b1 && t < 80);
        if (FRAME !== 1'b1) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: FRAME=%b after 80 cycles, required a pulse", tag, FRAME);
        end
    endtask

    // Release reset and check the first units slot: 2 blank cycles, 6 showing '0'
    task automatic release_and_check(input string tag);
        @(negedge CLK);
        RESET = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge CLK); #1;
            check_direct($sformatf("%s_%0d", tag, i), (i < 2) ? 4'hF : 4'hE,
                         (i < 2) ? 7'h7F : 7'b1000000, (i == 0));
        end
    endtask

    // Monitor: one queued frame per FRAME pulse, every cycle of it checked
    always @(posedge CLK) begin : monitor
        #1;
        if (RESET === 1'b1) begin
            mon_active = 1'b0;
        end else begin
            if (mon_active) begin
                if (mon_j < mon_cur.ncyc) begin
                    mon_j++;
                    check_cycle(mon_cur, mon_j);
                end else begin
                    if (mon_cur.ncyc == 31) begin
                        n_cmp++;
                        if (FRAME !== 1'b1) begin
                            n_fail++;
                            $display("FAIL frame_period: FRAME=%b 32 cycles after previous, required 1", FRAME);
                        end
                    end
                    mon_active = 1'b0;
                end
            end
            if (!mon_active && FRAME === 1'b1) begin
                if (mon_skip) begin
                    mon_skip = 1'b0;
                end else if (q.size() > 0) begin
                    mon_cur    = q.pop_front();
                    mon_active = 1'b1;
                    mon_j      = 0;
                end
            end
        end
    end

    initial begin : stimulus
        RESET = 1'b1; LOAD = 1'b0;
        BCD_T = 4'd0; BCD_H = 4'd0; BCD_D = 4'd0; BCD_U = 4'd0;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            check_direct($sformatf("reset_%0d", i), 4'hF, 7'h7F, 1'b0);
        end
        mon_skip = 1'b1;
        push_exp(4'd0, 4'd0, 4'd0, 4'd0, 31);
        release_and_check("startup");

        // Frame 1 shows zeros; mid-frame LOAD appears in frame 2
        wait_frame("frame1");
        push_exp(4'd1, 4'd2, 4'd3, 4'd4, 31);
        repeat (10) @(posedge CLK);
        #1;
        do_load(4'd1, 4'd2, 4'd3, 4'd4);

        // Two LOADs in one frame: last one wins
        wait_frame("frame2");
        push_exp(4'd9, 4'd0, 4'd1, 4'd2, 31);
        repeat (5) @(posedge CLK);
        #1;
        do_load(4'd5, 4'd6, 4'd7, 4'd8);
        repeat (10) @(posedge CLK);
        #1;
        do_load(4'd9, 4'd0, 4'd1, 4'd2);

        // LOAD on the boundary cycle bypasses into the frame starting then
        wait_frame("frame3");
        push_exp(4'd8, 4'd7, 4'd6, 4'd5, 31);
        repeat (31) @(posedge CLK);
        #1;
        do_load(4'd8, 4'd7, 4'd6, 4'd5);

        // Non-BCD units value shows a dash
        push_exp(4'd1, 4'd2, 4'd3, 4'd12, 31);
        repeat (3) @(posedge CLK);
        #1;
        do_load(4'd1, 4'd2, 4'd3, 4'd12);

        wait_frame("frame5");
        push_exp(4'd0, 4'd0, 4'd5, 4'd0, 31);
        repeat (4) @(posedge CLK);
        #1;
        do_load(4'd0, 4'd0, 4'd5, 4'd0);

        // Frame 7 is cut short by a reset in the hundreds slot
        wait_frame("frame6");
        push_exp(4'd0, 4'd0, 4'd0, 4'd0, 16);
        repeat (4) @(posedge CLK);
        #1;
        do_load(4'd0, 4'd0, 4'd0, 4'd0);

        wait_frame("frame7");
        repeat (2) @(posedge CLK);
        #1;
        do_load(4'd9, 4'd9, 4'd9, 4'd9);
        repeat (17) @(posedge CLK);
        #1;
        RESET = 1'b1;
        @(posedge CLK); #1;
        check_direct("reset_mid", 4'hF, 7'h7F, 1'b0);
        mon_skip = 1'b1;
        @(posedge CLK); #1;
        release_and_check("restart");

        n_cmp++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: %0d expected frames left, required 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
